// File: rtl/tile_link_mem_responder.sv
// tile_link_mem_responder
//   Manager-side TileLink endpoint backed by a 2^ADDR_W x 64-bit word array.
//   Serves built-in Get/GetBlock/Put/PutBlock acquires and 8-beat releases,
//   answering with grants. One transaction is in flight at a time.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   io_acquire_*            acquire channel (client -> manager)
//   io_release_*            release channel (client -> manager)
//   io_grant_*              grant channel (manager -> client)
//   io_error                sticky flag: unsupported acquire consumed
module tile_link_mem_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BEATS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        io_acquire_ready,
  input  logic        io_acquire_valid,
  input  logic [25:0] io_acquire_bits_addr_block,
  input  logic [1:0]  io_acquire_bits_client_xact_id,
  input  logic [2:0]  io_acquire_bits_addr_beat,
  input  logic        io_acquire_bits_is_builtin_type,
  input  logic [2:0]  io_acquire_bits_a_type,
  input  logic [11:0] io_acquire_bits_union,
  input  logic [63:0] io_acquire_bits_data,
  output logic        io_release_ready,
  input  logic        io_release_valid,
  input  logic [25:0] io_release_bits_addr_block,
  input  logic [1:0]  io_release_bits_client_xact_id,
  input  logic        io_release_bits_voluntary,
  input  logic [63:0] io_release_bits_data,
  input  logic        io_grant_ready,
  output logic        io_grant_valid,
  output logic [2:0]  io_grant_bits_addr_beat,
  output logic [1:0]  io_grant_bits_client_xact_id,
  output logic        io_grant_bits_manager_xact_id,
  output logic        io_grant_bits_is_builtin_type,
  output logic [3:0]  io_grant_bits_g_type,
  output logic [63:0] io_grant_bits_data,
  output logic        io_error
);

  localparam logic [2:0] LastBeat = 3'(BEATS - 1);

  localparam logic [3:0] GVolAck   = 4'd0;
  localparam logic [3:0] GPutAck   = 4'd3;
  localparam logic [3:0] GGetBeat  = 4'd4;
  localparam logic [3:0] GGetBlock = 4'd5;

  typedef enum logic [2:0] {
    StIdle,
    StPutCollect,
    StRelCollect,
    StGrantData,
    StGrantAck
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  id_q, id_d;
  logic [25:0] block_q, block_d;
  logic [3:0]  gtype_q, gtype_d;
  logic        vol_q, vol_d;
  logic        single_q, single_d;
  logic        err_q, err_d;

  logic [63:0] mem [2**ADDR_W];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;

  // Word index is the low ADDR_W bits of {block, beat}; upper bits alias.
  logic [28:0] acq_full, acq0_full, rel0_full, lat_full;
  logic [ADDR_W-1:0] acq_idx, acq0_idx, rel0_idx, lat_idx;

  assign acq_full  = {io_acquire_bits_addr_block, io_acquire_bits_addr_beat};
  assign acq0_full = {io_acquire_bits_addr_block, 3'd0};
  assign rel0_full = {io_release_bits_addr_block, 3'd0};
  assign lat_full  = {block_q, cnt_q};
  assign acq_idx   = acq_full[ADDR_W-1:0];
  assign acq0_idx  = acq0_full[ADDR_W-1:0];
  assign rel0_idx  = rel0_full[ADDR_W-1:0];
  assign lat_idx   = lat_full[ADDR_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{acq_full, acq0_full, rel0_full, lat_full,
                         io_acquire_bits_union[11:9], io_acquire_bits_union[0]};

  logic [7:0] acq_mask;
  assign acq_mask = io_acquire_bits_union[8:1];

  logic acq_fire, rel_fire, gnt_fire;
  assign acq_fire = io_acquire_valid & io_acquire_ready;
  assign rel_fire = io_release_valid & io_release_ready;
  assign gnt_fire = io_grant_valid & io_grant_ready;

  // State and transaction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      id_q     <= '0;
      block_q  <= '0;
      gtype_q  <= '0;
      vol_q    <= 1'b0;
      single_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      block_q  <= block_d;
      gtype_q  <= gtype_d;
      vol_q    <= vol_d;
      single_q <= single_d;
      err_q    <= err_d;
    end
  end

  // Memory array is deliberately not reset; writes survive a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_wmask[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Next-state and memory write control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    block_d   = block_q;
    gtype_d   = gtype_q;
    vol_d     = vol_q;
    single_d  = single_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = lat_idx;
    mem_wdata = io_acquire_bits_data;
    mem_wmask = acq_mask;

    case (state_q)
      StIdle: begin
        if (rel_fire) begin
          mem_we    = 1'b1;
          mem_waddr = rel0_idx;
          mem_wdata = io_release_bits_data;
          mem_wmask = 8'hFF;
          cnt_d     = 3'd1;
          vol_d     = io_release_bits_voluntary;
          id_d      = io_release_bits_client_xact_id;
          block_d   = io_release_bits_addr_block;
          state_d   = StRelCollect;
        end else if (acq_fire) begin
          if (!io_acquire_bits_is_builtin_type || io_acquire_bits_a_type[2]) begin
            // Unsupported: beat is swallowed, no grant.
            err_d = 1'b1;
          end else begin
            id_d    = io_acquire_bits_client_xact_id;
            block_d = io_acquire_bits_addr_block;
            case (io_acquire_bits_a_type[1:0])
              2'd0: begin
                cnt_d    = io_acquire_bits_addr_beat;
                single_d = 1'b1;
                gtype_d  = GGetBeat;
                state_d  = StGrantData;
              end
              2'd1: begin
                cnt_d    = 3'd0;
                single_d = 1'b0;
                gtype_d  = GGetBlock;
                state_d  = StGrantData;
              end
              2'd2: begin
                mem_we    = 1'b1;
                mem_waddr = acq_idx;
                gtype_d   = GPutAck;
                state_d   = StGrantAck;
              end
              default: begin
                mem_we    = 1'b1;
                mem_waddr = acq0_idx;
                cnt_d     = 3'd1;
                state_d   = StPutCollect;
              end
            endcase
          end
        end
      end
      StPutCollect: begin
        if (acq_fire) begin
          // Beat position comes from the counter, not from addr_beat.
          mem_we = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == LastBeat) begin
            gtype_d = GPutAck;
            state_d = StGrantAck;
          end
        end
      end
      StRelCollect: begin
        if (rel_fire) begin
          mem_we    = 1'b1;
          mem_wdata = io_release_bits_data;
          mem_wmask = 8'hFF;
          cnt_d     = cnt_q + 3'd1;
          if (cnt_q == LastBeat) begin
            if (vol_q) begin
              gtype_d = GVolAck;
              state_d = StGrantAck;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      StGrantData: begin
        if (gnt_fire) begin
          cnt_d = cnt_q + 3'd1;
          if (single_q || cnt_q == LastBeat) begin
            cnt_d   = 3'd0;
            state_d = StIdle;
          end
        end
      end
      StGrantAck: begin
        if (gnt_fire) begin
          cnt_d   = 3'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    io_acquire_ready        = 1'b0;
    io_release_ready        = 1'b0;
    io_grant_valid          = 1'b0;
    io_grant_bits_addr_beat = 3'd0;
    io_grant_bits_data      = 64'd0;
    case (state_q)
      StIdle: begin
        io_release_ready = 1'b1;
        io_acquire_ready = !io_release_valid;  // release has priority
      end
      StPutCollect: io_acquire_ready = 1'b1;
      StRelCollect: io_release_ready = 1'b1;
      StGrantData: begin
        io_grant_valid          = 1'b1;
        io_grant_bits_addr_beat = cnt_q;
        io_grant_bits_data      = mem[lat_idx];
      end
      StGrantAck: io_grant_valid = 1'b1;
      default: ;
    endcase
  end

  assign io_grant_bits_client_xact_id  = id_q;
  assign io_grant_bits_manager_xact_id = 1'b0;
  assign io_grant_bits_is_builtin_type = 1'b1;
  assign io_grant_bits_g_type          = gtype_q;
  assign io_error                      = err_q;

endmodule

// File: doc/tile_link_mem_responder.md
Name: tile_link_mem_responder

Overview:
Manager-side TileLink endpoint: the block sits at the outer side of the client enqueuer and answers its acquire and release traffic. It backs an on-chip 64-bit word array. It services built-in Get/GetBlock/Put/PutBlock acquires and 8-beat voluntary releases, returning grants. Probes are never issued; finishes are not used.

Parameters:
ADDR_W, 10, word-index width; memory depth 2^ADDR_W x 64 bits
BEATS, 8, beats per block (fixed; beat counters 3 bits)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
io_acquire_ready  out  1  acquire accepted
io_acquire_valid  in  1  acquire valid
io_acquire_bits_addr_block  in  26  block address
io_acquire_bits_client_xact_id  in  2  client transaction id
io_acquire_bits_addr_beat  in  3  beat within block
io_acquire_bits_is_builtin_type  in  1  must be 1
io_acquire_bits_a_type  in  3  0 Get, 1 GetBlock, 2 Put, 3 PutBlock
io_acquire_bits_union  in  12  [8:1] byte write mask for Put/PutBlock; other bits ignored
io_acquire_bits_data  in  64  put data
io_release_ready  out  1  release beat accepted
io_release_valid  in  1  release beat valid
io_release_bits_addr_block  in  26  block address
io_release_bits_client_xact_id  in  2  client id
io_release_bits_voluntary  in  1  ack required when 1
io_release_bits_data  in  64  release data
io_grant_ready  in  1  grant accepted
io_grant_valid  out  1  grant beat valid
io_grant_bits_addr_beat  out  3  beat index
io_grant_bits_client_xact_id  out  2  echoed id
io_grant_bits_manager_xact_id  out  1  constant 0
io_grant_bits_is_builtin_type  out  1  constant 1
io_grant_bits_g_type  out  4  0 voluntaryAck, 3 putAck, 4 getDataBeat, 5 getDataBlock
io_grant_bits_data  out  64  read data; 0 for acks
io_error  out  1  sticky: unsupported acquire seen

Behaviour:
- Word index = {addr_block, beat}[ADDR_W-1:0]; upper bits truncated (aliasing wrap). Memory is not reset; read is combinational from the array; write takes effect at the accepting clock edge.
- States: IDLE, PUT_COLLECT, REL_COLLECT, GRANT_DATA, GRANT_ACK.
- Reset (async): state IDLE, beat counter 0, io_grant_valid 0, io_error 0, latched id/addr/g_type 0. Ready outputs follow the state immediately after reset.
- IDLE: io_release_ready=1. io_acquire_ready = !io_release_valid, so release wins when both are valid. On accept:
  - Get: latch id, block and addr_beat; go to GRANT_DATA with 1 beat, g_type 4.
  - GetBlock: latch id and block, beat counter 0; go to GRANT_DATA with 8 beats, g_type 5.
  - Put: write bytes where union[i+1]=1 at (addr_block, addr_beat); go to GRANT_ACK with g_type 3.
  - PutBlock: write beat 0 (masked), counter 1; go to PUT_COLLECT.
  - Release: write beat 0, counter 1; latch voluntary and id; go to REL_COLLECT.
  - is_builtin_type=0 or a_type>=4: consume the beat, set io_error, stay in IDLE, issue no grant.
- PUT_COLLECT: io_acquire_ready=1, io_release_ready=0. Each beat is written at the counter value; incoming addr_beat is ignored. After beat 7, go to GRANT_ACK with g_type 3.
- REL_COLLECT: io_release_ready=1, io_acquire_ready=0. Beats are written at the counter value. After beat 7, go to GRANT_ACK with g_type 0 if voluntary, else to IDLE.
- GRANT_DATA: io_grant_valid=1; data = mem[index], addr_beat = counter (Get: the latched beat). Valid and bits hold until io_grant_ready. Each fire advances the counter. On the last fire, go to IDLE.
- GRANT_ACK: io_grant_valid=1, addr_beat=0, data=0. On fire, go to IDLE.
- All readies are 0 in the GRANT states. Exactly one transaction is in flight. First grant valid = the cycle after the final request beat is accepted. No grant is lost or repeated under backpressure.
- Reset mid-operation: the transaction is abandoned, memory writes already made are kept, and no grant is issued.

Test Plan:
- Put at block 0x5, beat 2, data 0x1122334455667788, mask 0xFF, then Get of the same -> putAck (g_type 3, id echoed), then getDataBeat returning 0x1122334455667788 with beat 2.
- PutBlock to block 0x10, beats data=beat*0x0101, then GetBlock -> one putAck, then 8 grants g_type 5, beats 0..7, correct data. Hold io_grant_ready low 3 cycles mid-burst: beat/data stable.
- Put with mask 0x0F over a known word -> only the low 4 bytes change.
- Release (voluntary=1, id 2) and acquire valid in the same cycle -> release accepted first, acquire stalls. After the 8th release beat, voluntaryAck g_type 0 id 2, then the acquire is accepted.
- Non-voluntary release -> 8 beats written, no grant; acquire with a_type 5 -> io_error=1, no grant.
- Assert reset during GRANT_DATA beat 4 -> io_grant_valid=0 immediately, state IDLE; a following Get works normally.
